obi_apb_bridge_nch: RTL

Parametrised OBI-to-APB bridge that decodes one OBI subordinate port into NUM_TARGETS APB completer channels. It sits between the peripheral OBI interconnect and the student/peripheral subsystems. It implements its own single-outstanding FSM rather than a crossbar plus per-channel converters. Beyond a plain splitter it adds:
- a per-target enable mask from ss_ctrl;
- an OBI error response on decode miss or disabled target;
- a PREADY timeout so that a hung subsystem cannot lock the bus.

---
 rtl/obi_apb_bridge_nch.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/obi_apb_bridge_nch.sv
// OBI-to-APB bridge with NUM_TARGETS APB completer channels.
// One OBI subordinate port is decoded into equally sized windows starting at
// ADDR_BASE. Only one transaction is outstanding at a time. Decode misses
// and disabled targets get an OBI error response without touching APB. A
// completer that holds PREADY low for TIMEOUT_CYCLES ACCESS cycles gets an
// error response instead of locking the bus.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   obi_*               OBI subordinate port (req/gnt, addr, we, be, wdata,
//                       aid, rvalid/rready, rdata, err, rid, parity lines)
//   ss_ctrl_icn         per-target enable mask, sampled at grant
//   apb_paddr/pwrite/pwdata/pstrb   shared APB request signals
//   apb_psel/penable    per-channel select and enable
//   apb_prdata/pready/pslverr       per-channel completer responses
module obi_apb_bridge_nch #(
  parameter int unsigned        NUM_TARGETS    = 4,
  parameter int unsigned        OBI_AW         = 32,
  parameter int unsigned        OBI_DW         = 32,
  parameter int unsigned        OBI_IDW        = 1,
  parameter int unsigned        APB_AW         = 32,
  parameter logic [OBI_AW-1:0]  ADDR_BASE      = 32'h0103_0000,
  parameter int unsigned        SS_SIZE_LOG2   = 8,
  parameter int unsigned        TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          obi_req,
  output logic                          obi_gnt,
  output logic                          obi_gntpar,
  input  logic [OBI_AW-1:0]             obi_addr,
  input  logic                          obi_we,
  input  logic [OBI_DW/8-1:0]           obi_be,
  input  logic [OBI_DW-1:0]             obi_wdata,
  input  logic [OBI_IDW-1:0]            obi_aid,
  output logic                          obi_rvalid,
  output logic                          obi_rvalidpar,
  input  logic                          obi_rready,
  output logic [OBI_DW-1:0]             obi_rdata,
  output logic                          obi_err,
  output logic [OBI_IDW-1:0]            obi_rid,
  input  logic [NUM_TARGETS-1:0]        ss_ctrl_icn,
  output logic [APB_AW-1:0]             apb_paddr,
  output logic                          apb_pwrite,
  output logic [OBI_DW-1:0]             apb_pwdata,
  output logic [OBI_DW/8-1:0]           apb_pstrb,
  output logic [NUM_TARGETS-1:0]        apb_psel,
  output logic [NUM_TARGETS-1:0]        apb_penable,
  input  logic [NUM_TARGETS*OBI_DW-1:0] apb_prdata,
  input  logic [NUM_TARGETS-1:0]        apb_pready,
  input  logic [NUM_TARGETS-1:0]        apb_pslverr
);

  localparam int unsigned IdxW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [OBI_AW:0]      NumTargetsW = OBI_AW'(NUM_TARGETS);
  localparam logic [NUM_TARGETS-1:0] SelOne    = NUM_TARGETS'(1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e                 r_state;
  logic [CntW-1:0]        r_cnt;
  logic [APB_AW-1:0]      r_paddr;
  logic                   r_pwrite;
  logic [OBI_DW-1:0]      r_pwdata;
  logic [OBI_DW/8-1:0]    r_pstrb;
  logic [NUM_TARGETS-1:0] r_psel;
  logic [NUM_TARGETS-1:0] r_penable;
  logic                   r_rvalid;
  logic [OBI_DW-1:0]      r_rdata;
  logic                   r_err;
  logic [OBI_IDW-1:0]     r_rid;

  // Decode in OBI_AW+1 bits so an address below the base cannot wrap into a hit.
  logic [OBI_AW:0]        w_off;
  logic [OBI_AW:0]        w_win;
  logic                   w_hit;
  logic [NUM_TARGETS-1:0] w_onehot;
  logic                   w_enabled;
  logic                   w_grant;

  assign w_off     = {1'b0, obi_addr} - {1'b0, ADDR_BASE};
  assign w_win     = w_off >> SS_SIZE_LOG2;
  assign w_hit     = (obi_addr >= ADDR_BASE) && (w_win < NumTargetsW);
  assign w_onehot  = SelOne << w_win[IdxW-1:0];
  assign w_enabled = w_hit && (|(w_onehot & ss_ctrl_icn));
  assign w_grant   = reset_n && obi_req && (r_state == StIdle);

  // r_psel is one-hot on the active channel, so it doubles as the response mux select.
  logic [OBI_DW-1:0] w_prdata;
  logic              w_pready;
  logic              w_pslverr;
  logic              w_timeout;

  always_comb begin
    w_prdata = '0;
    for (int i = 0; i < int'(NUM_TARGETS); i++) begin
      if (r_psel[i]) w_prdata = w_prdata | apb_prdata[i*OBI_DW +: OBI_DW];
    end
  end

  assign w_pready  = |(apb_pready & r_psel);
  assign w_pslverr = |(apb_pslverr & r_psel);
  // r_cnt counts completed ACCESS cycles, so +1 includes the current one.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && ((32'(r_cnt) + 32'd1) == TIMEOUT_CYCLES);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_psel    <= '0;
      r_penable <= '0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_rid     <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_grant) begin
            r_rid   <= obi_aid;
            r_rdata <= '0;
            if (w_enabled) begin
              // Shared APB signals only change for a real access, so they
              // hold their last values across error responses.
              r_paddr  <= obi_addr[APB_AW-1:0];
              r_pwrite <= obi_we;
              r_pwdata <= obi_wdata;
              r_pstrb  <= obi_be;
              r_psel   <= w_onehot;
              r_err    <= 1'b0;
              r_state  <= StSetup;
            end else begin
              r_err    <= 1'b1;
              r_rvalid <= 1'b1;
              r_state  <= StResp;
            end
          end
        end
        StSetup: begin
          r_penable <= r_psel;
          r_cnt     <= '0;
          r_state   <= StAccess;
        end
        StAccess: begin
          if (w_pready) begin
            r_rdata   <= r_pwrite ? '0 : w_prdata;
            r_err     <= w_pslverr;
            r_rvalid  <= 1'b1;
            r_psel    <= '0;
            r_penable <= '0;
            r_cnt     <= '0;
            r_state   <= StResp;
          end else if (w_timeout) begin
            r_rdata   <= '0;
            r_err     <= 1'b1;
            r_rvalid  <= 1'b1;
            r_psel    <= '0;
            r_penable <= '0;
            r_cnt     <= '0;
            r_state   <= StResp;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StResp: begin
          if (obi_rready) begin
            r_rvalid <= 1'b0;
            r_state  <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign obi_gnt       = w_grant;
  assign obi_gntpar    = ~w_grant;
  assign obi_rvalid    = r_rvalid;
  assign obi_rvalidpar = ~r_rvalid;
  assign obi_rdata     = r_rdata;
  assign obi_err       = r_err;
  assign obi_rid       = r_rid;
  assign apb_paddr     = r_paddr;
  assign apb_pwrite    = r_pwrite;
  assign apb_pwdata    = r_pwdata;
  assign apb_pstrb     = r_pstrb;
  assign apb_psel      = r_psel;
  assign apb_penable   = r_penable;

endmodule
